// File: rtl/echo_i2s_tx.sv
// Echo-to-DAC I2S transmitter: width reduction, sample FIFO, mono I2S serializer with its own bclk/lrck.
// `ECHO_TX_SAT_EN` selects saturating reduction (default truncates); no backpressure, a full FIFO drops the sample and flags overflow.
module echo_i2s_tx_fifo #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic [AW:0]  o_level
);
  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_wr;
  logic          w_rd;

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign w_wr    = i_push & (~r_level[AW] | i_pop);
  assign w_rd    = i_pop & (r_level != '0);
  assign o_dat   = r_mem[r_rp];
  assign o_level = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_dat;
  end
endmodule

module echo_i2s_tx #(
  parameter int SINGLE_DAC_WIDTH = 19,
  parameter int OUT_WIDTH        = 16,
  parameter int FIFO_AW          = 3,
  parameter int BCLK_DIV         = 4
) (
  input  logic                        clk,
  input  logic                        ce,
  input  logic [SINGLE_DAC_WIDTH-1:0] Echo_In,
  input  logic                        echo_Done,
  output logic                        bclk,
  output logic                        lrck,
  output logic                        sdata,
  output logic [FIFO_AW:0]            fifo_level,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int FW   = 2 * OUT_WIDTH;
  localparam int CNTW = $clog2(FW);
  localparam int DIVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIVW-1:0]      r_div;
  logic [CNTW-1:0]      r_bitcnt;
  logic [FW-1:0]        r_shift;
  logic                 r_bclk;
  logic                 r_lrck;
  logic                 r_sdata;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 w_tick;
  logic                 w_fall;
  logic                 w_wrap;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic [CNTW-1:0]      w_bitcnt_nxt;
  logic [OUT_WIDTH-1:0] w_sample;
  logic [OUT_WIDTH-1:0] w_fifo_dat;
  logic [FIFO_AW:0]     w_level;

`ifdef ECHO_TX_SAT_EN
  logic [SINGLE_DAC_WIDTH-OUT_WIDTH:0] w_hi;
  assign w_hi = Echo_In[SINGLE_DAC_WIDTH-1:OUT_WIDTH-1];

  // In range only when every bit above the output sign bit matches it.
  always_comb begin
    w_sample = Echo_In[OUT_WIDTH-1:0];
    if (!(&w_hi) && (|w_hi))
      w_sample = Echo_In[SINGLE_DAC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^Echo_In[SINGLE_DAC_WIDTH-1:OUT_WIDTH];
  assign w_sample    = Echo_In[OUT_WIDTH-1:0];
`endif

  echo_i2s_tx_fifo #(
    .W  (OUT_WIDTH),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (ce),
    .i_push  (echo_Done),
    .i_pop   (w_pop),
    .i_dat   (w_sample),
    .o_dat   (w_fifo_dat),
    .o_level (w_level)
  );

  assign w_tick       = (r_div == DIVW'(BCLK_DIV - 1));
  assign w_fall       = w_tick & r_bclk;
  assign w_wrap       = w_fall & (r_bitcnt == CNTW'(FW - 1));
  assign w_empty      = (w_level == '0);
  assign w_full       = w_level[FIFO_AW];
  assign w_pop        = w_wrap & ~w_empty;
  assign w_bitcnt_nxt = w_wrap ? '0 : r_bitcnt + CNTW'(1);

  always_ff @(posedge clk or negedge ce) begin
    if (!ce) begin
      r_div       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_sdata     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIVW'(1);
      if (w_tick) r_bclk <= ~r_bclk;
      // sdata lags the shifter by one bit clock, giving the I2S one-bit delay.
      if (w_fall) begin
        r_bitcnt <= w_bitcnt_nxt;
        r_lrck   <= (w_bitcnt_nxt >= CNTW'(OUT_WIDTH));
        r_sdata  <= r_shift[FW-1];
        if (w_wrap) r_shift <= w_pop ? {w_fifo_dat, w_fifo_dat} : '0;
        else        r_shift <= {r_shift[FW-2:0], 1'b0};
      end
      if (echo_Done & w_full & ~w_pop) r_overflow  <= 1'b1;
      if (w_wrap & w_empty)            r_underflow <= 1'b1;
    end
  end

  assign bclk       = r_bclk;
  assign lrck       = r_lrck;
  assign sdata      = r_sdata;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
endmodule

// File: tb/tb_echo_i2s_tx.sv
// Directed bench for echo_i2s_tx at OUT_WIDTH=16, BCLK_DIV=2, FIFO_AW=3; cycle 0 is the last edge-relative slot after reset release.
module tb_echo_i2s_tx;
  localparam int SW  = 19;
  localparam int OW  = 16;
  localparam int AW  = 3;
  localparam int DIV = 2;

  logic          clk = 1'b0;
  logic          ce = 1'b0;
  logic [SW-1:0] Echo_In = '0;
  logic          echo_Done = 1'b0;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [SW-1:0] din;
    logic [OW-1:0] exp_sat;
    logic [OW-1:0] exp_trunc;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  echo_i2s_tx #(
    .SINGLE_DAC_WIDTH (SW),
    .OUT_WIDTH        (OW),
    .FIFO_AW          (AW),
    .BCLK_DIV         (DIV)
  ) dut (
    .clk        (clk),
    .ce         (ce),
    .Echo_In    (Echo_In),
    .echo_Done  (echo_Done),
    .bclk       (bclk),
    .lrck       (lrck),
    .sdata      (sdata),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic push(input logic [SW-1:0] v);
    Echo_In   = v;
    echo_Done = 1'b1;
    step();
    echo_Done = 1'b0;
  endtask

  task automatic do_reset();
    ce        = 1'b0;
    echo_Done = 1'b0;
    step();
    step();
    chk("reset_outputs", {bclk, lrck, sdata, fifo_level, overflow, underflow}, '0);
    ce  = 1'b1;
    cyc = 0;
  endtask

  // Frame loaded at wrap cycle 'base': bit (32-k) is on sdata at base+4k, bit 0 at base+128.
  task automatic capture(input int base, output logic [2*OW-1:0] fr, output bit lr_ok);
    fr    = '0;
    lr_ok = 1'b1;
    for (int k = 1; k <= 2*OW; k++) begin
      step_to(base + 4*k);
      fr[2*OW-k] = sdata;
      if (lrck !== ((k >= OW) && (k < 2*OW))) lr_ok = 1'b0;
    end
  endtask

  task automatic chk_frame(input string name, input int base, input logic [OW-1:0] s);
    logic [2*OW-1:0] fr;
    bit ok;
    capture(base, fr, ok);
    chk(name, fr, {s, s});
    chk({name, "_lrck"}, ok, 1);
  endtask

  function automatic logic [OW-1:0] exp_of(input int i);
`ifdef ECHO_TX_SAT_EN
    return vecs[i].exp_sat;
`else
    return vecs[i].exp_trunc;
`endif
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [2*OW-1:0] fr;
    bit ok;
    int bclk_bad;
    int lrck_bad;
    int sdata_bad;

    vecs[0] = '{19'h01234, 16'h1234, 16'h1234};
    vecs[1] = '{19'h08000, 16'h7FFF, 16'h8000};
    vecs[2] = '{19'h70000, 16'h8000, 16'h0000};
    vecs[3] = '{19'h7FFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{19'h07FFF, 16'h7FFF, 16'h7FFF};
    vecs[5] = '{19'h78000, 16'h8000, 16'h8000};
    vecs[6] = '{19'h0A5C3, 16'h7FFF, 16'hA5C3};
    vecs[7] = '{19'h40001, 16'h8000, 16'h0001};

    // Reset and idle
    do_reset();
    bclk_bad = 0; lrck_bad = 0; sdata_bad = 0;
    for (int n = 1; n <= 260; n++) begin
      step();
      if (bclk !== (((n / 2) % 2) == 1)) bclk_bad++;
      if (lrck !== (((n / 4) % 32) >= 16)) lrck_bad++;
      if (sdata !== 1'b0) sdata_bad++;
      if (n == 1)   chk("idle_all_zero", {bclk, lrck, sdata, fifo_level, overflow, underflow}, '0);
      if (n == 2)   chk("idle_first_bclk", bclk, 1);
      if (n == 127) chk("idle_underflow_before_wrap", underflow, 0);
      if (n == 128) chk("idle_underflow_at_wrap", underflow, 1);
    end
    chk("idle_bclk_pattern_errs", bclk_bad, 0);
    chk("idle_lrck_pattern_errs", lrck_bad, 0);
    chk("idle_sdata_errs", sdata_bad, 0);

    // Single sample
    do_reset();
    chk("single_level0", fifo_level, 0);
    push(19'h01234);
    chk("single_level1", fifo_level, 1);
    capture(0, fr, ok);
    chk("single_frame0_silent", fr, 0);
    chk("single_level_after_pop", fifo_level, 0);
    chk("single_no_underflow", underflow, 0);
    chk_frame("single_frame1", 128, 16'h1234);
    chk("single_underflow_after", underflow, 1);

    // Width reduction table
    do_reset();
    push(vecs[0].din);
    capture(0, fr, ok);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) push(vecs[i+1].din);
      chk_frame($sformatf("vec%0d", i), 128*(i+1), exp_of(i));
    end
    chk("vec_no_overflow", overflow, 0);

    // Overflow: nine pushes, ninth dropped
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push(19'(32'h1100 + i));
      if (i == 8) begin
        chk("ovf_level_full", fifo_level, 8);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_level_after9", fifo_level, 8);
    chk("ovf_flag", overflow, 1);
    step_to(128);
    chk("ovf_level_after_pop", fifo_level, 7);
    for (int f = 1; f <= 8; f++) chk_frame($sformatf("ovf_frame%0d", f), 128*f, 16'(32'h1100 + f));
    chk_frame("ovf_dropped_absent", 128*9, 16'h0000);

    // Full FIFO, push in the wrap cycle
    do_reset();
    for (int i = 1; i <= 8; i++) push(19'(32'h2200 + i));
    chk("full_level", fifo_level, 8);
    step_to(127);
    push(19'h05A5A);
    chk("full_wrap_level", fifo_level, 8);
    chk("full_wrap_overflow", overflow, 0);
    for (int f = 1; f <= 8; f++) chk_frame($sformatf("full_frame%0d", f), 128*f, 16'(32'h2200 + f));
    chk_frame("full_wrap_sample", 128*9, 16'h5A5A);

    // Empty FIFO, push in the wrap cycle
    do_reset();
    step_to(127);
    push(19'h03C3C);
    chk("empty_wrap_underflow", underflow, 1);
    chk("empty_wrap_level", fifo_level, 1);
    chk_frame("empty_wrap_zero", 128, 16'h0000);
    chk_frame("empty_wrap_sample", 256, 16'h3C3C);
    chk("empty_wrap_level_end", fifo_level, 0);

    // Reset mid-frame with three samples queued
    do_reset();
    for (int i = 1; i <= 4; i++) push(19'(32'h3300 + i));
    step_to(128 + 4*20 + 1);
    chk("mid_pre_lrck", lrck, 1);
    chk("mid_pre_level", fifo_level, 3);
    #2 ce = 1'b0;
    #1;
    chk("mid_async_zero", {bclk, lrck, sdata, fifo_level, overflow, underflow}, '0);
    do_reset();
    chk("mid_level_after", fifo_level, 0);
    capture(0, fr, ok);
    chk("mid_first_frame_silent", fr, 0);
    chk("mid_underflow_at_wrap", underflow, 1);
    chk_frame("mid_second_frame_zero", 128, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/echo_i2s_tx.md
# echo_i2s_tx

Output-side partner of the echo stage. It accepts the widened echo samples strobed by `echo_Done`, reduces them to DAC width and buffers them in a small internal FIFO. It then serializes each sample as a mono I2S stream (the same sample in the left and right slots) toward the DAC. It sits between the echo block and the codec pins and generates its own bit clock and word clock from `clk`.

## Interface
Parameters:
- `SINGLE_DAC_WIDTH`, 19: width of the incoming echo sample, signed two's complement.
- `OUT_WIDTH`, 16: serialized sample width, equal to the I2S slot length in bit clocks.
- `FIFO_AW`, 3: FIFO address width; depth is 2^FIFO_AW entries.
- `BCLK_DIV`, 4: `clk` cycles per half period of `bclk`; must be at least 1.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `ce`, input, 1: asynchronous active-low reset.
- `Echo_In`, input, SINGLE_DAC_WIDTH: echo sample.
- `echo_Done`, input, 1: one-cycle strobe; `Echo_In` is valid in this cycle.
- `bclk`, output, 1: I2S bit clock.
- `lrck`, output, 1: word clock; 0 means left slot, 1 means right slot.
- `sdata`, output, 1: serial data, MSB first.
- `fifo_level`, output, FIFO_AW+1: current FIFO occupancy.
- `overflow`, output, 1: sticky flag; a sample was dropped because the FIFO was full.
- `underflow`, output, 1: sticky flag; a frame started with the FIFO empty.

## Operation
- Reset (`ce`=0) clears all outputs and all state to 0: `bclk`, `lrck`, `sdata`, `fifo_level`, `overflow`, `underflow`, divider, bit counter and shift register. Reset asserted mid-frame aborts the frame immediately and discards the FIFO contents.
- Width reduction (`ECHO_TX_SAT_EN` defined): `Echo_In` is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Push: in a cycle with `echo_Done`=1, the reduced sample is written to the FIFO.
  - If the FIFO is full after any pop in the same cycle, the sample is dropped and `overflow` is set.
  - A push and a pop in the same cycle on a full FIFO therefore succeed, and `fifo_level` is unchanged.
- Divider: `bclk` toggles each time the divider reaches BCLK_DIV-1, after which the divider restarts at 0.
- Bit counter: `bitcnt` runs 0..2*OUT_WIDTH-1 and advances on each `bclk` falling edge, i.e. the `clk` cycle in which `bclk` goes 1 to 0.
  - `lrck` = (`bitcnt` >= OUT_WIDTH).
- Frame load happens when `bitcnt` wraps from 2*OUT_WIDTH-1 to 0:
  - FIFO not empty: pop one sample S and load the shift register with {S, S}.
  - FIFO empty: load zeros and set `underflow`. A push in the same cycle is stored; the pop does not see it.
- The first frame after reset is silent (zeros) and does not set `underflow`. The first pop happens at the first wrap.
- Serial data uses the I2S one-bit delay:
  - For `bitcnt`=k with k >= 1, `sdata` carries frame bit 2*OUT_WIDTH-k, MSB first.
  - At k=0, `sdata` carries the LSB of the previous frame's right slot (0 after reset).
- `overflow` and `underflow` clear only on reset.

## Timing
- `bclk` period is 2*BCLK_DIV `clk` cycles; a frame is 4*OUT_WIDTH*BCLK_DIV `clk` cycles.
- `lrck`, `sdata` and `bitcnt` change only in the `clk` cycle of a `bclk` falling edge, so they are stable at the `bclk` rising edge.
- Push latency: `fifo_level` increments one cycle after `echo_Done`.
- Output latency: a sample written into an empty FIFO appears on `sdata` (MSB) one bit clock after the next frame wrap.
- Sustained rate: at most one pushed sample per frame without overflow once the FIFO is full. Outputs are registered.

## Configuration
- `ECHO_TX_SAT_EN` defined: saturating clamp as described in Operation.
- `ECHO_TX_SAT_EN` not defined: plain truncation to `Echo_In[OUT_WIDTH-1:0]` (two's-complement wrap). Everything else is identical.

## Test plan
All scenarios use OUT_WIDTH=16, BCLK_DIV=2, FIFO_AW=3.
- **Reset and idle:** release reset with no pushes.
  - All outputs are 0 until the first `bclk` toggle 2 cycles later; `bclk` period is 4 cycles; `lrck` period is 128 cycles.
  - `underflow` is set at the first wrap (cycle 128), not before.
- **Single sample:** push `Echo_In`=19'h01234 before the first wrap.
  - The following frame serializes 16'h1234 in the left slot and again in the right slot, each MSB one `bclk` after the `lrck` edge.
  - `fifo_level` goes 0, then 1, then 0.
- **Saturation:** push 19'h08000, then 19'h70000, then 19'h7FFFF.
  - With `ECHO_TX_SAT_EN`: frames carry 16'h7FFF, 16'h8000, 16'hFFFF.
  - Without it: frames carry 16'h8000, 16'h0000, 16'hFFFF.
- **Overflow:** push 9 samples back-to-back with no wrap in between.
  - `fifo_level`=8, the 9th sample is dropped, `overflow`=1.
  - Frames then emit samples 1..8 in order.
- **Simultaneous events:**
  - Full FIFO, push in the wrap cycle: sample accepted, `overflow` stays 0, `fifo_level` stays 8.
  - Empty FIFO, push in the wrap cycle: zero frame, `underflow`=1, `fifo_level`=1.
- **Reset mid-frame:** assert `ce`=0 while `bitcnt`=20 with 3 samples queued.
  - All outputs are 0 immediately; after release `fifo_level`=0 and the first frame is silent.
